// File: rtl/armleocpu_axi2simple_burst_converter_if.sv
// AXI4 slave-side channel bundle for the burst converter.
// The master modport is the AXI master side; the slave modport is the bridge side.
interface armleocpu_axi2simple_burst_converter_if #(
    parameter int ADDR_WIDTH = 34,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
);
    logic                      axi_awvalid;
    logic                      axi_awready;
    logic [ADDR_WIDTH-1:0]     axi_awaddr;
    logic [ID_WIDTH-1:0]       axi_awid;
    logic [7:0]                axi_awlen;
    logic [2:0]                axi_awsize;
    logic [1:0]                axi_awburst;

    logic                      axi_wvalid;
    logic                      axi_wready;
    logic [DATA_WIDTH-1:0]     axi_wdata;
    logic [DATA_WIDTH/8-1:0]   axi_wstrb;
    logic                      axi_wlast;

    logic                      axi_bvalid;
    logic                      axi_bready;
    logic [1:0]                axi_bresp;
    logic [ID_WIDTH-1:0]       axi_bid;

    logic                      axi_arvalid;
    logic                      axi_arready;
    logic [ADDR_WIDTH-1:0]     axi_araddr;
    logic [ID_WIDTH-1:0]       axi_arid;
    logic [7:0]                axi_arlen;
    logic [2:0]                axi_arsize;
    logic [1:0]                axi_arburst;

    logic                      axi_rvalid;
    logic                      axi_rready;
    logic [DATA_WIDTH-1:0]     axi_rdata;
    logic [1:0]                axi_rresp;
    logic [ID_WIDTH-1:0]       axi_rid;
    logic                      axi_rlast;

    modport master (
        output axi_awvalid, axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst,
        input  axi_awready,
        output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        input  axi_wready,
        input  axi_bvalid, axi_bresp, axi_bid,
        output axi_bready,
        output axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst,
        input  axi_arready,
        input  axi_rvalid, axi_rdata, axi_rresp, axi_rid, axi_rlast,
        output axi_rready
    );

    modport slave (
        input  axi_awvalid, axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst,
        output axi_awready,
        input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
        output axi_wready,
        output axi_bvalid, axi_bresp, axi_bid,
        input  axi_bready,
        input  axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst,
        output axi_arready,
        output axi_rvalid, axi_rdata, axi_rresp, axi_rid, axi_rlast,
        input  axi_rready
    );
endinterface

// File: rtl/armleocpu_axi2simple_burst_converter.sv
// AXI4 slave to simple-bus bridge: one simple-bus access per AXI beat,
// FIXED/INCR/WRAP bursts, round-robin between read and write addresses.
//
// state     | meaning
// IDLE      | arbitrate AR/AW, latch burst parameters
// RD_ACCESS | read strobe for current beat, capture read_data/response
// RD_RESP   | present R beat until rready
// WR_DATA   | accept W beats, one write strobe per beat
// WR_RESP   | present B until bready
module armleocpu_axi2simple_burst_converter #(
    parameter int ADDR_WIDTH = 34,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    armleocpu_axi2simple_burst_converter_if.slave bus,
    input  logic                      address_error,
    input  logic                      write_error,
    output logic [ADDR_WIDTH-1:0]     address,
    output logic                      write,
    output logic [DATA_WIDTH-1:0]     write_data,
    output logic [DATA_WIDTH/8-1:0]   write_byteenable,
    output logic                      read,
    input  logic [DATA_WIDTH-1:0]     read_data
);
    localparam int                    STROBES    = DATA_WIDTH / 8;
    localparam logic [2:0]            SIZE_FULL  = 3'($clog2(STROBES));
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STROBES - 1);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, RD_ACCESS, RD_RESP, WR_DATA, WR_RESP} state_t;

    state_t                  state_q, state_d;
    logic                    rr_read_q, rr_read_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [7:0]              len_q, len_d;
    logic [1:0]              burst_q, burst_d;
    logic                    illegal_q, illegal_d;
    logic [7:0]              beat_q, beat_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [1:0]              err_q, err_d;

    logic                    pick_read, pick_write, last_beat;
    logic [ADDR_WIDTH-1:0]   aligned, incr_addr, wrap_mask, next_addr;

    function automatic logic is_illegal(input logic [1:0] b, input logic [2:0] s,
                                        input logic [7:0] l);
        return (b == 2'b11) || (s != SIZE_FULL) ||
               ((b == BURST_WRAP) && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
    endfunction

    assign pick_read  = bus.axi_arvalid && (!bus.axi_awvalid || rr_read_q);
    assign pick_write = bus.axi_awvalid && !pick_read;
    assign last_beat  = (beat_q == len_q);

    // Only beat 0 may carry unaligned low bits; every later beat is aligned.
    assign aligned   = addr_q & ALIGN_MASK;
    assign incr_addr = aligned + ADDR_WIDTH'(STROBES);
    assign wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << SIZE_FULL) - ADDR_WIDTH'(1);

    always_comb begin
        next_addr = incr_addr;
        case (burst_q)
            BURST_FIXED: next_addr = aligned;
            BURST_INCR:  next_addr = incr_addr;
            BURST_WRAP:  next_addr = (aligned & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rr_read_d = rr_read_q;
        addr_d    = addr_q;
        id_d      = id_q;
        len_d     = len_q;
        burst_d   = burst_q;
        illegal_d = illegal_q;
        beat_d    = beat_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        err_d     = err_q;
        bus.axi_arready = 1'b0;
        bus.axi_awready = 1'b0;
        bus.axi_wready  = 1'b0;
        bus.axi_rvalid  = 1'b0;
        bus.axi_rlast   = 1'b0;
        bus.axi_bvalid  = 1'b0;
        read  = 1'b0;
        write = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_read) begin
                    bus.axi_arready = 1'b1;
                    addr_d    = bus.axi_araddr;
                    id_d      = bus.axi_arid;
                    len_d     = bus.axi_arlen;
                    burst_d   = bus.axi_arburst;
                    illegal_d = is_illegal(bus.axi_arburst, bus.axi_arsize, bus.axi_arlen);
                    beat_d    = 8'd0;
                    err_d     = RESP_OKAY;
                    rr_read_d = 1'b0;
                    state_d   = RD_ACCESS;
                end else if (pick_write) begin
                    bus.axi_awready = 1'b1;
                    addr_d    = bus.axi_awaddr;
                    id_d      = bus.axi_awid;
                    len_d     = bus.axi_awlen;
                    burst_d   = bus.axi_awburst;
                    illegal_d = is_illegal(bus.axi_awburst, bus.axi_awsize, bus.axi_awlen);
                    beat_d    = 8'd0;
                    err_d     = RESP_OKAY;
                    rr_read_d = 1'b1;
                    state_d   = WR_DATA;
                end
            end
            RD_ACCESS: begin
                read    = !illegal_q;
                rdata_d = illegal_q ? '0 : read_data;
                rresp_d = illegal_q ? RESP_SLVERR :
                          (address_error ? RESP_DECERR : RESP_OKAY);
                state_d = RD_RESP;
            end
            RD_RESP: begin
                bus.axi_rvalid = 1'b1;
                bus.axi_rlast  = last_beat;
                if (bus.axi_rready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = next_addr;
                        beat_d  = beat_q + 8'd1;
                        state_d = RD_ACCESS;
                    end
                end
            end
            WR_DATA: begin
                bus.axi_wready = 1'b1;
                if (bus.axi_wvalid) begin
                    write = !illegal_q;
                    // DECERR is sticky and outranks SLVERR from later beats.
                    if (illegal_q)
                        err_d = RESP_SLVERR;
                    else if (address_error)
                        err_d = RESP_DECERR;
                    else if (write_error && err_q != RESP_DECERR)
                        err_d = RESP_SLVERR;
                    if (last_beat) begin
                        state_d = WR_RESP;
                    end else begin
                        addr_d = next_addr;
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            WR_RESP: begin
                bus.axi_bvalid = 1'b1;
                if (bus.axi_bready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_read_q <= 1'b1;
            addr_q    <= '0;
            id_q      <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            illegal_q <= 1'b0;
            beat_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_read_q <= rr_read_d;
            addr_q    <= addr_d;
            id_q      <= id_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            illegal_q <= illegal_d;
            beat_q    <= beat_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            err_q     <= err_d;
        end
    end

    assign address          = addr_q;
    assign write_data       = bus.axi_wdata;
    assign write_byteenable = bus.axi_wstrb;
    assign bus.axi_rdata    = rdata_q;
    assign bus.axi_rresp    = rresp_q;
    assign bus.axi_rid      = id_q;
    assign bus.axi_bid      = id_q;
    assign bus.axi_bresp    = err_q;
endmodule

// File: tb/tb_armleocpu_axi2simple_burst_converter.sv
// Directed self-checking bench for the AXI4 to simple-bus burst converter.
module tb_armleocpu_axi2simple_burst_converter;
    localparam int AW = 34;
    localparam int IW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          address_error, write_error;
    logic [AW-1:0] address;
    logic          write, read;
    logic [DW-1:0] write_data, read_data;
    logic [3:0]    write_byteenable;

    logic          ae_on = 1'b0, we_on = 1'b0;
    logic [AW-1:0] ae_addr = '0, we_addr = '0;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] rd_addrs[$];
    logic [AW-1:0] wr_addrs[$];
    logic [DW-1:0] wr_datas[$];
    logic [3:0]    wr_bes[$];
    bit            order[$];
    int            ar_hs = 0;
    int            b_hs  = 0;

    armleocpu_axi2simple_burst_converter_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

    armleocpu_axi2simple_burst_converter #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .address_error    (address_error),
        .write_error      (write_error),
        .address          (address),
        .write            (write),
        .write_data       (write_data),
        .write_byteenable (write_byteenable),
        .read             (read),
        .read_data        (read_data)
    );

    always #5 clk = ~clk;

    assign read_data     = (address == 34'h10) ? 32'hCAFEF00D : (32'hD000_0000 | address[31:0]);
    assign address_error = ae_on && (address == ae_addr);
    assign write_error   = we_on && (address == we_addr);

    always @(negedge clk) begin
        if (read) rd_addrs.push_back(address);
        if (write) begin
            wr_addrs.push_back(address);
            wr_datas.push_back(write_data);
            wr_bes.push_back(write_byteenable);
        end
        if (bus.axi_arvalid && bus.axi_arready) begin
            order.push_back(1'b0);
            ar_hs++;
        end
        if (bus.axi_awvalid && bus.axi_awready) order.push_back(1'b1);
        if (bus.axi_bvalid && bus.axi_bready) b_hs++;
    end

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_ar(input logic [AW-1:0] a, input logic [IW-1:0] id,
                           input logic [7:0] len, input logic [1:0] burst, output bit ok);
        bus.axi_araddr = a; bus.axi_arid = id; bus.axi_arlen = len;
        bus.axi_arburst = burst; bus.axi_arsize = 3'd2; bus.axi_arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.axi_arready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1 bus.axi_arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [AW-1:0] a, input logic [IW-1:0] id,
                           input logic [7:0] len, input logic [1:0] burst, output bit ok);
        bus.axi_awaddr = a; bus.axi_awid = id; bus.axi_awlen = len;
        bus.axi_awburst = burst; bus.axi_awsize = 3'd2; bus.axi_awvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.axi_awready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1 bus.axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [3:0] strb, input int gap, output bit ok);
        repeat (gap) @(posedge clk);
        #1 bus.axi_wdata = d; bus.axi_wstrb = strb; bus.axi_wvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.axi_wready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1 bus.axi_wvalid = 1'b0;
    endtask

    task automatic recv_r(output logic [DW-1:0] d, output logic [1:0] resp, output logic [IW-1:0] id,
                          output logic last, output bit ok);
        bus.axi_rready = 1'b1;
        ok = 1'b0; d = '0; resp = '0; id = '0; last = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.axi_rvalid) begin
                ok = 1'b1; d = bus.axi_rdata; resp = bus.axi_rresp;
                id = bus.axi_rid; last = bus.axi_rlast;
                break;
            end
        end
        @(posedge clk); #1 bus.axi_rready = 1'b0;
    endtask

    task automatic recv_b(output logic [1:0] resp, output logic [IW-1:0] id, output bit ok);
        bus.axi_bready = 1'b1;
        ok = 1'b0; resp = '0; id = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.axi_bvalid) begin
                ok = 1'b1; resp = bus.axi_bresp; id = bus.axi_bid;
                break;
            end
        end
        @(posedge clk); #1 bus.axi_bready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.axi_arready, bus.axi_awready, bus.axi_wready, bus.axi_rvalid,
             bus.axi_bvalid, read, write} !== 7'b0) begin
            errors++;
            $display("FAIL reset_handshakes: got %b, expected 0000000",
                     {bus.axi_arready, bus.axi_awready, bus.axi_wready, bus.axi_rvalid,
                      bus.axi_bvalid, read, write});
        end
        checks++;
        if ({bus.axi_rdata, bus.axi_rresp, bus.axi_bresp, bus.axi_rid, address} !== '0) begin
            errors++;
            $display("FAIL reset_regs: rdata=%h rresp=%b bresp=%b rid=%h addr=%h, expected all 0",
                     bus.axi_rdata, bus.axi_rresp, bus.axi_bresp, bus.axi_rid, address);
        end
        @(posedge clk); #1 rst = 1'b0;
        bus.axi_wvalid = 1'b1; bus.axi_wdata = 32'h1234_5678; bus.axi_wstrb = 4'hF;
        @(negedge clk);
        checks++;
        if (bus.axi_wready !== 1'b0 || write !== 1'b0) begin
            errors++;
            $display("FAIL w_before_aw: wready=%b write=%b, expected 0 0", bus.axi_wready, write);
        end
        @(posedge clk); #1 bus.axi_wvalid = 1'b0;
    endtask

    task automatic test_single_read();
        bit ok; logic [DW-1:0] d; logic [1:0] resp; logic [IW-1:0] id; logic last;
        int rd0 = rd_addrs.size();
        int ar0 = ar_hs;
        send_ar(34'h10, 4'd3, 8'd0, 2'b01, ok);
        recv_r(d, resp, id, last, ok);
        checks++;
        if (!ok || ar_hs - ar0 != 1) begin
            errors++;
            $display("FAIL single_read_handshake: ok=%0d ar_handshakes=%0d, expected 1 1", ok, ar_hs - ar0);
        end
        checks++;
        if (rd_addrs.size() - rd0 != 1 || rd_addrs[rd0] !== 34'h10) begin
            errors++;
            $display("FAIL single_read_pulse: count=%0d, expected 1 pulse at 0x10", rd_addrs.size() - rd0);
        end
        checks++;
        if ({d, resp, id, last} !== {32'hCAFEF00D, 2'b00, 4'd3, 1'b1}) begin
            errors++;
            $display("FAIL single_read_beat: data=%h resp=%b id=%h last=%b, expected cafef00d 00 3 1",
                     d, resp, id, last);
        end
    endtask

    task automatic test_incr_write();
        bit ok, all_ok; logic [1:0] resp; logic [IW-1:0] id;
        logic [3:0] strbs [4] = '{4'hF, 4'h1, 4'h3, 4'hC};
        int wr0 = wr_addrs.size();
        int b0  = b_hs;
        all_ok = 1'b1;
        send_aw(34'h100, 4'd6, 8'd3, 2'b01, ok);
        all_ok &= ok;
        for (int i = 0; i < 4; i++) begin
            send_w(32'h1111_0000 + 32'(i), strbs[i], i % 2 * 2, ok);
            all_ok &= ok;
        end
        recv_b(resp, id, ok);
        all_ok &= ok;
        checks++;
        if (!all_ok || wr_addrs.size() - wr0 != 4) begin
            errors++;
            $display("FAIL incr_write_count: ok=%0d pulses=%0d, expected 1 4", all_ok, wr_addrs.size() - wr0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addrs[wr0+i] !== 34'h100 + 34'(4*i) || wr_datas[wr0+i] !== 32'h1111_0000 + 32'(i)
                    || wr_bes[wr0+i] !== strbs[i]) begin
                    errors++;
                    $display("FAIL incr_write_beat%0d: addr=%h data=%h be=%h, expected %h %h %h", i,
                             wr_addrs[wr0+i], wr_datas[wr0+i], wr_bes[wr0+i],
                             34'h100 + 34'(4*i), 32'h1111_0000 + 32'(i), strbs[i]);
                end
            end
        end
        checks++;
        if (resp !== 2'b00 || id !== 4'd6 || b_hs - b0 != 1) begin
            errors++;
            $display("FAIL incr_write_b: bresp=%b bid=%h b_count=%0d, expected 00 6 1", resp, id, b_hs - b0);
        end
    endtask

    task automatic test_wrap_read();
        bit ok; logic [DW-1:0] d; logic [1:0] resp; logic [IW-1:0] id; logic last;
        logic [AW-1:0] exp_addr [4] = '{34'h38, 34'h3C, 34'h30, 34'h34};
        int rd0 = rd_addrs.size();
        send_ar(34'h38, 4'd2, 8'd3, 2'b10, ok);
        for (int i = 0; i < 4; i++) begin
            recv_r(d, resp, id, last, ok);
            checks++;
            if (!ok || d !== (32'hD000_0000 | exp_addr[i][31:0]) || last !== (i == 3) || resp !== 2'b00
                || id !== 4'd2) begin
                errors++;
                $display("FAIL wrap_read_beat%0d: ok=%0d data=%h last=%b resp=%b id=%h, expected data %h last %0d",
                         i, ok, d, last, resp, id, 32'hD000_0000 | exp_addr[i][31:0], i == 3);
            end
        end
        checks++;
        if (rd_addrs.size() - rd0 != 4) begin
            errors++;
            $display("FAIL wrap_read_count: pulses=%0d, expected 4", rd_addrs.size() - rd0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_addrs[rd0+i] !== exp_addr[i]) begin
                    errors++;
                    $display("FAIL wrap_read_addr%0d: got %h, expected %h", i, rd_addrs[rd0+i], exp_addr[i]);
                end
            end
        end
    endtask

    task automatic test_arbitration();
        int nr = 0, nw = 0;
        int o0;
        apply_reset();
        o0 = order.size();
        bus.axi_araddr = 34'h20; bus.axi_arid = 4'd1; bus.axi_arlen = 8'd0;
        bus.axi_arburst = 2'b01; bus.axi_arsize = 3'd2;
        bus.axi_awaddr = 34'h40; bus.axi_awid = 4'd2; bus.axi_awlen = 8'd0;
        bus.axi_awburst = 2'b01; bus.axi_awsize = 3'd2;
        bus.axi_wdata = 32'hAAAA_5555; bus.axi_wstrb = 4'hF;
        bus.axi_rready = 1'b1; bus.axi_bready = 1'b1; bus.axi_wvalid = 1'b1;
        bus.axi_arvalid = 1'b1; bus.axi_awvalid = 1'b1;
        for (int i = 0; i < 100 && (nr < 2 || nw < 2); i++) begin
            @(negedge clk);
            if (bus.axi_arvalid && bus.axi_arready) nr++;
            if (bus.axi_awvalid && bus.axi_awready) nw++;
            @(posedge clk); #1;
            if (nr == 2) bus.axi_arvalid = 1'b0;
            if (nw == 2) bus.axi_awvalid = 1'b0;
        end
        repeat (6) @(posedge clk);
        #1 bus.axi_rready = 1'b0; bus.axi_bready = 1'b0; bus.axi_wvalid = 1'b0;
        bus.axi_arvalid = 1'b0; bus.axi_awvalid = 1'b0;
        checks++;
        if (order.size() - o0 != 4) begin
            errors++;
            $display("FAIL arb_count: accepted=%0d, expected 4", order.size() - o0);
        end else begin
            checks++;
            if ({order[o0], order[o0+1], order[o0+2], order[o0+3]} !== 4'b0101) begin
                errors++;
                $display("FAIL arb_order: got %b (0=read), expected 0101",
                         {order[o0], order[o0+1], order[o0+2], order[o0+3]});
            end
        end
    endtask

    task automatic test_errors();
        bit ok, all_ok; logic [1:0] resp; logic [IW-1:0] id; logic [DW-1:0] d; logic last;
        int rd0;
        all_ok = 1'b1;
        ae_addr = 34'h204; ae_on = 1'b1;
        we_addr = 34'h208; we_on = 1'b1;
        send_aw(34'h200, 4'd7, 8'd2, 2'b01, ok);
        all_ok &= ok;
        for (int i = 0; i < 3; i++) begin
            send_w(32'h2222_0000 + 32'(i), 4'hF, 0, ok);
            all_ok &= ok;
        end
        recv_b(resp, id, ok);
        all_ok &= ok;
        ae_on = 1'b0; we_on = 1'b0;
        checks++;
        if (!all_ok || resp !== 2'b11 || id !== 4'd7) begin
            errors++;
            $display("FAIL write_decerr_sticky: ok=%0d bresp=%b bid=%h, expected 1 11 7", all_ok, resp, id);
        end

        rd0 = rd_addrs.size();
        send_ar(34'h300, 4'd9, 8'd1, 2'b11, ok);
        for (int i = 0; i < 2; i++) begin
            recv_r(d, resp, id, last, ok);
            checks++;
            if (!ok || resp !== 2'b10 || d !== '0 || last !== (i == 1) || id !== 4'd9) begin
                errors++;
                $display("FAIL illegal_read_beat%0d: ok=%0d resp=%b data=%h last=%b id=%h, expected 10 0 %0d 9",
                         i, ok, resp, d, last, id, i == 1);
            end
        end
        checks++;
        if (rd_addrs.size() != rd0) begin
            errors++;
            $display("FAIL illegal_read_strobe: pulses=%0d, expected 0", rd_addrs.size() - rd0);
        end

        ae_addr = 34'h50; ae_on = 1'b1;
        send_ar(34'h50, 4'd4, 8'd0, 2'b01, ok);
        recv_r(d, resp, id, last, ok);
        ae_on = 1'b0;
        checks++;
        if (!ok || resp !== 2'b11 || last !== 1'b1) begin
            errors++;
            $display("FAIL read_decerr: ok=%0d rresp=%b last=%b, expected 1 11 1", ok, resp, last);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok, seen; logic [DW-1:0] d; logic [1:0] resp; logic [IW-1:0] id; logic last;
        send_ar(34'h400, 4'd1, 8'd7, 2'b01, ok);
        recv_r(d, resp, id, last, ok);
        recv_r(d, resp, id, last, ok);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.axi_rvalid) begin seen = 1'b1; break; end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (!seen || bus.axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_burst_rvalid: reached_rresp=%0d rvalid=%b, expected 1 0", seen, bus.axi_rvalid);
        end
        @(posedge clk); #1 rst = 1'b0;
        bus.axi_rready = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.axi_rvalid) seen = 1'b1;
        end
        @(posedge clk); #1 bus.axi_rready = 1'b0;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_burst_dropped: rvalid=1 after reset, expected 0");
        end
        send_ar(34'h10, 4'd5, 8'd0, 2'b01, ok);
        recv_r(d, resp, id, last, ok);
        checks++;
        if (!ok || id !== 4'd5 || d !== 32'hCAFEF00D || resp !== 2'b00 || last !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_read: ok=%0d rid=%h data=%h resp=%b last=%b, expected 1 5 cafef00d 00 1",
                     ok, id, d, resp, last);
        end
    endtask

    initial begin
        bus.axi_awvalid = 1'b0; bus.axi_awaddr = '0; bus.axi_awid = '0; bus.axi_awlen = '0;
        bus.axi_awsize = 3'd2; bus.axi_awburst = 2'b01;
        bus.axi_wvalid = 1'b0; bus.axi_wdata = '0; bus.axi_wstrb = '0; bus.axi_wlast = 1'b0;
        bus.axi_bready = 1'b0;
        bus.axi_arvalid = 1'b0; bus.axi_araddr = '0; bus.axi_arid = '0; bus.axi_arlen = '0;
        bus.axi_arsize = 3'd2; bus.axi_arburst = 2'b01;
        bus.axi_rready = 1'b0;

        test_reset();
        test_single_read();
        test_incr_write();
        test_wrap_read();
        test_arbitration();
        test_errors();
        test_reset_mid_burst();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/armleocpu_axi2simple_burst_converter.md
Name: armleocpu_axi2simple_burst_converter

Overview:
- AXI4 slave to simple-bus bridge that adds full burst support (FIXED/INCR/WRAP, len 0..255) and a parametrised data width.
- Fair round-robin arbitration between read and write when both are requested.
- Decoupled AW/W acceptance.
- Sits behind the address router in front of zero-based peripherals; performs exactly one simple-bus access per AXI beat.

Parameters:
ADDR_WIDTH  34  address width, both AXI and simple side
ID_WIDTH  4  AXI ID width
DATA_WIDTH  32  32 or 64; STROBES=DATA_WIDTH/8, SIZE_FULL=log2(STROBES)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
axi_awvalid/awready  in/out  1  AW handshake
axi_awaddr  in  ADDR_WIDTH  write start address
axi_awid  in  ID_WIDTH  write ID
axi_awlen  in  8  beats-1
axi_awsize  in  3  beat size
axi_awburst  in  2  burst type
axi_wvalid/wready  in/out  1  W handshake
axi_wdata  in  DATA_WIDTH  write data
axi_wstrb  in  STROBES  byte strobes
axi_wlast  in  1  ignored; beats counted from awlen
axi_bvalid/bready  out/in  1  B handshake
axi_bresp  out  2  write response
axi_bid  out  ID_WIDTH  = latched awid
axi_arvalid/arready, axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst  read address channel; widths as AW
axi_rvalid/rready  out/in  1  R handshake
axi_rdata  out  DATA_WIDTH  registered read data
axi_rresp  out  2  read response
axi_rid  out  ID_WIDTH  = latched arid
axi_rlast  out  1  high on final beat
address_error  in  1  current address undecoded -> DECERR 2'b11
write_error  in  1  write rejected -> SLVERR 2'b10
address  out  ADDR_WIDTH  beat address
write  out  1  one-cycle write strobe
write_data  out  DATA_WIDTH  = axi_wdata
write_byteenable  out  STROBES  = axi_wstrb
read  out  1  one-cycle read strobe
read_data  in  DATA_WIDTH  combinational data for address

Behaviour:
- Reset (async, any state, mid-burst included): state IDLE; all ready/valid/read/write 0; rresp/bresp/rdata/id/counters 0; round-robin pointer = read-first. Aborted burst is dropped; no B/R is issued for it.
- States: IDLE, RD_ACCESS, RD_RESP, WR_DATA, WR_RESP.
- IDLE, arbitration: only arvalid -> read; only awvalid -> write; both -> pointer side wins; pointer flips to the other side after each accepted address. Winner gets its ready high for one cycle. The cycle latches addr, id, len, burst and size, clears beat counter and error flag, and goes to RD_ACCESS / WR_DATA.
- Legality at acceptance: burst==2'b11, size!=SIZE_FULL, or WRAP with len not in {1,3,7,15} -> burst is illegal. Every beat still completes the handshake with SLVERR (2'b10), read/write strobes stay 0, rdata=0.
- RD_ACCESS, 1 cycle: read=1, address=beat addr. Capture read_data into rdata; rresp = address_error ? 11 : 00. Go to RD_RESP.
- RD_RESP: rvalid=1; rlast=(beat==len). rdata/rresp/rid stable until rready.
  - rready && last -> IDLE.
  - rready && not last -> advance address, beat+1 -> RD_ACCESS.
  - Throughput: 1 beat per 2 cycles minimum.
- WR_DATA: wready=1. Each wvalid cycle: write=1 (legal burst only), address=beat addr. Sticky error: DECERR if address_error, else SLVERR if write_error; DECERR overrides SLVERR. On last beat -> WR_RESP, else advance. W before AW is not accepted (wready=0 in IDLE).
- WR_RESP: bvalid=1, bresp = sticky error (00 if none), stable until bready -> IDLE.
- Address advance (beat address is always aligned to SIZE_FULL; low bits from AXI are kept only for beat 0, then aligned):
  - FIXED: address unchanged.
  - INCR: +STROBES, wraps at ADDR_WIDTH (no 4KB check).
  - WRAP: boundary = (len+1)*STROBES; new = (addr & ~(boundary-1)) | ((addr+STROBES) & (boundary-1)).
- Outside RD_ACCESS/WR_DATA: address = latched beat address; read = write = 0.

Test Plan:
- Single INCR read, len=0, addr 0x10, read_data 0xCAFEF00D -> arready 1 cycle, read pulse @0x10, rvalid with rdata 0xCAFEF00D, rresp 00, rlast 1, rid echoes arid.
- INCR write len=3 @0x100, W beats 0..3 with wvalid gaps -> write pulses @0x100, 0x104, 0x108, 0x10C; single bvalid, bresp 00, bid = awid.
- WRAP read len=3 @0x38 (DATA_WIDTH=32) -> read addresses 0x38, 0x30, 0x34, 0x38... is wrong; required sequence 0x38, 0x3C, 0x30, 0x34; rlast on 4th beat only.
- arvalid and awvalid high together for three consecutive transactions -> service order read, write, read.
- Write len=2 with address_error on beat 1 and write_error on beat 2 -> bresp 11; illegal burst 2'b11 read len=1 -> two R beats with SLVERR, read never pulses.
- Reset asserted in RD_RESP, mid-burst of len=7 -> rvalid drops immediately; after release, IDLE accepts a new arvalid with ID 5 and rid=5.
